// File: rtl/pwm_capture.sv
// PWM input capture: period and high time in prescaled ticks, one-cycle valid per period, sticky timeout.
// Optional 3-clk glitch filter on the synchronized input: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 pwm_i,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic                 valid_o,
    output logic                 timeout_o,
    output logic                 level_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t               state, state_nxt;
    logic [1:0]           sync_q;
    logic                 s, s_d, rise, tick;
    logic [DIV_WIDTH-1:0] freq_count;
    logic [CNT_WIDTH-1:0] per_cnt, high_cnt, per_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], pwm_i};
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [2:0] f;
    logic       s_q;

    // s only moves once three consecutive samples agree; otherwise it holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f   <= 3'b000;
            s_q <= 1'b0;
        end else begin
            f <= {f[1:0], sync_q[1]};
            if (f == 3'b111)      s_q <= 1'b1;
            else if (f == 3'b000) s_q <= 1'b0;
        end
    end
    assign s = s_q;
`else
    assign s = sync_q[1];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) s_d <= 1'b0;
        else          s_d <= s;
    end

    assign rise    = s & ~s_d;
    assign level_o = s;

    // Free-running prescaler, not re-phased on edges
    assign tick = enable && (freq_count >= div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              freq_count <= '0;
        else if (!enable || tick)  freq_count <= '0;
        else                       freq_count <= freq_count + 1'b1;
    end

    // Period seen at a rise includes the rise cycle's tick; saturates so nothing wraps
    assign per_next = (tick && per_cnt != CNT_MAX) ? per_cnt + 1'b1 : per_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_nxt = MEASURE;
                MEASURE: if (!rise && tick && per_cnt == CNT_MAX) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt   <= '0;
            high_cnt  <= '0;
            period_o  <= '0;
            high_o    <= '0;
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
        end else if (!enable) begin
            per_cnt  <= '0;
            high_cnt <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        per_cnt  <= '0;
                        high_cnt <= {{(CNT_WIDTH-1){1'b0}}, tick};
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_o  <= per_next;
                        high_o    <= high_cnt;
                        valid_o   <= 1'b1;
                        timeout_o <= 1'b0;
                        per_cnt   <= '0;
                        high_cnt  <= {{(CNT_WIDTH-1){1'b0}}, tick};
                    end else if (tick) begin
                        if (per_cnt == CNT_MAX) begin
                            timeout_o <= 1'b1;
                        end else begin
                            per_cnt <= per_cnt + 1'b1;
                            if (s && high_cnt != CNT_MAX) high_cnt <= high_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_WIDTH=8); expectations follow PWM_CAPTURE_GLITCH_FILTER_EN if defined.
module tb_pwm_capture;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [15:0] div = '0;
    logic       pwm_i = 1'b0;
    logic [7:0] period_o, high_o;
    logic       valid_o, timeout_o, level_o;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int vcnt     = 0;
    int lp       = 0;
    int lh       = 0;
    int pwm_per  = 10;
    int pwm_hi   = 0;
    int phase    = 0;
    int g0       = 0;
    int g1       = 0;

    pwm_capture #(.DIV_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .div(div), .pwm_i(pwm_i),
        .period_o(period_o), .high_o(high_o), .valid_o(valid_o),
        .timeout_o(timeout_o), .level_o(level_o)
    );

    always #5 clk = ~clk;

    // Record every valid cycle and the values it carried
    always @(posedge clk) begin
        #1;
        if (valid_o) begin
            vcnt++;
            lp = int'(period_o);
            lh = int'(high_o);
        end
    end

    task automatic set_pwm(input int per, input int hi);
        pwm_per = per;
        pwm_hi  = hi;
        phase   = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            pwm_i = (phase < pwm_hi) || (phase >= g0 && phase < g1);
            phase = (phase + 1) % pwm_per;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        div     = '0;
        pwm_i   = 1'b0;
        g0 = 0; g1 = 0;
        set_pwm(10, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pwm_i   = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (period_o !== 8'd0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period_o); end
        if (high_o !== 8'd0)   begin n_fail++; $display("FAIL reset_high: got %0d expected 0", high_o); end
        if (valid_o !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", valid_o); end
        if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b expected 0", timeout_o); end
        if (level_o !== 1'b0)  begin n_fail++; $display("FAIL reset_level: got %0b expected 0", level_o); end
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        enable = 1'b1;
        set_pwm(10, 3);
        vcnt = 0;
        run(10);
        n_checks++;
        if (vcnt !== 0) begin n_fail++; $display("FAIL basic_first_rise: got %0d valids expected 0", vcnt); end
        run(30);
        pwm_hi = 0;
        run(10);
        n_checks += 3;
        if (vcnt !== 3) begin n_fail++; $display("FAIL basic_valid_count: got %0d expected 3", vcnt); end
        if (lp !== 10)  begin n_fail++; $display("FAIL basic_period: got %0d expected 10", lp); end
        if (lh !== 3)   begin n_fail++; $display("FAIL basic_high: got %0d expected 3", lh); end
    endtask

    task automatic test_prescaled();
        apply_reset();
        div    = 16'd4;
        enable = 1'b1;
        set_pwm(100, 25);
        vcnt = 0;
        run(210);
        n_checks += 3;
        if (vcnt !== 2) begin n_fail++; $display("FAIL presc_valid_count: got %0d expected 2", vcnt); end
        if (lp !== 20)  begin n_fail++; $display("FAIL presc_period: got %0d expected 20", lp); end
        if (lh !== 5)   begin n_fail++; $display("FAIL presc_high: got %0d expected 5", lh); end
    endtask

    task automatic test_timeout();
        int first;
        apply_reset();
        enable = 1'b1;
        set_pwm(10, 3);
        run(20);
        vcnt  = 0;
        first = 0;
        pwm_i = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk);
            #1;
            if (timeout_o && first == 0) first = cyc;
            @(negedge clk);
            if (cyc == 3) pwm_i = 1'b0;
        end
        n_checks += 4;
        if (first !== 257 + LAT) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", first, 257 + LAT); end
        if (vcnt !== 1)          begin n_fail++; $display("FAIL timeout_valids: got %0d expected 1", vcnt); end
        if (period_o !== 8'd10)  begin n_fail++; $display("FAIL timeout_period_hold: got %0d expected 10", period_o); end
        if (high_o !== 8'd3)     begin n_fail++; $display("FAIL timeout_high_hold: got %0d expected 3", high_o); end
        set_pwm(10, 3);
        vcnt = 0;
        run(10);
        n_checks += 2;
        if (vcnt !== 0)        begin n_fail++; $display("FAIL recover_first_rise: got %0d valids expected 0", vcnt); end
        if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL recover_sticky: got %0b expected 1", timeout_o); end
        run(10);
        n_checks += 3;
        if (vcnt !== 1)         begin n_fail++; $display("FAIL recover_valid: got %0d expected 1", vcnt); end
        if (lp !== 10)          begin n_fail++; $display("FAIL recover_period: got %0d expected 10", lp); end
        if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL recover_clear: got %0b expected 0", timeout_o); end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        enable = 1'b1;
        set_pwm(10, 3);
        vcnt = 0;
        run(27);
        n_checks++;
        if (vcnt !== 2) begin n_fail++; $display("FAIL en_pre_valids: got %0d expected 2", vcnt); end
        run(1);
        enable = 1'b0;
        vcnt = 0;
        run(20);
        n_checks += 3;
        if (vcnt !== 0)         begin n_fail++; $display("FAIL en_low_valids: got %0d expected 0", vcnt); end
        if (period_o !== 8'd10) begin n_fail++; $display("FAIL en_low_period: got %0d expected 10", period_o); end
        if (high_o !== 8'd3)    begin n_fail++; $display("FAIL en_low_high: got %0d expected 3", high_o); end
        enable = 1'b1;
        run(8);
        n_checks++;
        if (vcnt !== 0) begin n_fail++; $display("FAIL en_first_rise: got %0d valids expected 0", vcnt); end
        run(14);
        n_checks += 3;
        if (vcnt !== 1) begin n_fail++; $display("FAIL en_resume_valid: got %0d expected 1", vcnt); end
        if (lp !== 10)  begin n_fail++; $display("FAIL en_resume_period: got %0d expected 10", lp); end
        if (lh !== 3)   begin n_fail++; $display("FAIL en_resume_high: got %0d expected 3", lh); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        enable = 1'b1;
        set_pwm(10, 3);
        run(27);
        n_checks++;
        if (period_o !== 8'd10) begin n_fail++; $display("FAIL rmid_pre_period: got %0d expected 10", period_o); end
        run(3);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks += 5;
        if (period_o !== 8'd0)  begin n_fail++; $display("FAIL rmid_period: got %0d expected 0", period_o); end
        if (high_o !== 8'd0)    begin n_fail++; $display("FAIL rmid_high: got %0d expected 0", high_o); end
        if (valid_o !== 1'b0)   begin n_fail++; $display("FAIL rmid_valid: got %0b expected 0", valid_o); end
        if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL rmid_timeout: got %0b expected 0", timeout_o); end
        if (level_o !== 1'b0)   begin n_fail++; $display("FAIL rmid_level: got %0b expected 0", level_o); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_glitch();
        apply_reset();
        enable = 1'b1;
        set_pwm(20, 5);
        run(30);
        vcnt = 0;
        g0 = 12; g1 = 14;
        run(20);
        g0 = 0; g1 = 0;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        n_checks += 3;
        if (vcnt !== 1) begin n_fail++; $display("FAIL glitch_reject_count: got %0d expected 1", vcnt); end
        if (lp !== 20)  begin n_fail++; $display("FAIL glitch_reject_period: got %0d expected 20", lp); end
        if (lh !== 5)   begin n_fail++; $display("FAIL glitch_reject_high: got %0d expected 5", lh); end
        vcnt = 0;
        g0 = 12; g1 = 15;
        run(20);
        g0 = 0; g1 = 0;
        n_checks += 3;
        if (vcnt !== 2) begin n_fail++; $display("FAIL pulse3_count: got %0d expected 2", vcnt); end
        if (lp !== 8)   begin n_fail++; $display("FAIL pulse3_period: got %0d expected 8", lp); end
        if (lh !== 3)   begin n_fail++; $display("FAIL pulse3_high: got %0d expected 3", lh); end
`else
        n_checks += 3;
        if (vcnt !== 2) begin n_fail++; $display("FAIL glitch_pass_count: got %0d expected 2", vcnt); end
        if (lp !== 8)   begin n_fail++; $display("FAIL glitch_pass_period: got %0d expected 8", lp); end
        if (lh !== 2)   begin n_fail++; $display("FAIL glitch_pass_high: got %0d expected 2", lh); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescaled();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
